// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiply controller for the EX-stage MUL.
// Latches operands on a MUL issue, consumes BITS_PER_CYCLE multiplier bits per
// cycle while holding the pipeline stalled, then pulses done_o for one cycle
// with the low WIDTH bits of the product on data_o. kill_i aborts a multiply
// in flight; non-MUL ALU codes are left to the single-cycle ALU.
module mul_sequencer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter logic [2:0]  MUL_CODE       = 3'b100
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             kill_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned N_ITER = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  // Reject parameter combinations the datapath cannot step through evenly.
  if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4)) ||
      ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_param
    $error("mul_sequencer: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     data_q, data_d;

  logic                 go_c;
  logic [WIDTH-1:0]     pp_c;
  logic [WIDTH-1:0]     pp_shift_c;
  logic [BITS_PER_CYCLE-1:0] pp_digit_c;

  // A MUL issue is only honoured out of reset, with no flush in the same cycle.
  assign go_c = rst_i && start_i && (ALUCtrl_i == MUL_CODE) && !kill_i;

  // Partial product mcand * (low digit of mplier), built as a small shift-add.
  always_comb begin
    pp_c       = '0;
    pp_shift_c = mcand_q;
    pp_digit_c = mplier_q[BITS_PER_CYCLE-1:0];
    for (int unsigned b = 0; b < BITS_PER_CYCLE; b++) begin
      if (pp_digit_c[0]) begin
        pp_c = pp_c + pp_shift_c;
      end
      pp_shift_c = pp_shift_c << 1;
      pp_digit_c = pp_digit_c >> 1;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (go_c) begin
          mcand_d  = data1_i;
          mplier_d = data2_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        if (kill_i) begin
          // Flush wins over completion; the previous result stays on data_o.
          state_d = ST_IDLE;
        end else begin
          acc_d    = acc_q + pp_c;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            data_d  = acc_q + pp_c;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // Result pulse is committed; the pipeline advances this cycle.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  // Stall rises in the issue cycle itself so the EX instruction is held.
  assign stall_o = (state_q == ST_RUN) || ((state_q == ST_IDLE) && go_c);
  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = (state_q == ST_DONE);
  assign data_o  = data_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: scoreboard bench for mul_sequencer at BITS_PER_CYCLE 1, 2, 4.
// All three instances see the same stimulus; expected products and done cycles
// are queued at issue time and checked by a negedge monitor.
module tb_mul_sequencer;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          kill;
  logic [2:0]    ctrl;
  logic [W-1:0]  d1, d2;
  logic [2:0]    stall, busy, done;
  logic [W-1:0]  dout [3];

  typedef struct {
    logic [W-1:0] data;
    int unsigned  cyc;
  } exp_t;

  exp_t         q0[$], q1[$], q2[$];
  int unsigned  n_chk = 0;
  int unsigned  n_fail = 0;
  int unsigned  cyc = 0;
  int unsigned  sc[3] = '{0, 0, 0};
  logic [W-1:0] last_data[3] = '{'0, '0, '0};
  int unsigned  nit[3] = '{32, 16, 8};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mul_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_b1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ALUCtrl_i(ctrl),
    .data1_i(d1), .data2_i(d2), .kill_i(kill),
    .stall_o(stall[0]), .busy_o(busy[0]), .done_o(done[0]), .data_o(dout[0]));

  mul_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(2)) u_b2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ALUCtrl_i(ctrl),
    .data1_i(d1), .data2_i(d2), .kill_i(kill),
    .stall_o(stall[1]), .busy_o(busy[1]), .done_o(done[1]), .data_o(dout[1]));

  mul_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_b4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ALUCtrl_i(ctrl),
    .data1_i(d1), .data2_i(d2), .kill_i(kill),
    .stall_o(stall[2]), .busy_o(busy[2]), .done_o(done[2]), .data_o(dout[2]));

  task automatic chk(input string nm, input int i, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got 0x%08h expected 0x%08h (cycle %0d)",
               nm, i, act, exp, cyc);
    end
  endtask

  function automatic int unsigned pending();
    return q0.size() + q1.size() + q2.size();
  endfunction

  task automatic qpush(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int i, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '{data: '0, cyc: 0};
    case (i)
      0: if (q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Reference: low W bits of the full product.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return p[W-1:0];
  endfunction

  // Monitor: on each done pulse check result, timing and stall length.
  task automatic mon_one(input int i);
    exp_t e;
    bit   ok;
    if (done[i] === 1'b1) begin
      chk("stall_in_done", i, W'(stall[i]), '0);
      chk("busy_in_done", i, W'(busy[i]), '0);
      chk("stall_len", i, W'(sc[i]), W'(nit[i] + 1));
      sc[i] = 0;
      qpop(i, ok, e);
      if (!ok) begin
        chk("unexpected_done", i, W'(done[i]), '0);
      end else begin
        chk("data", i, dout[i], e.data);
        chk("done_cycle", i, W'(cyc), W'(e.cyc));
        last_data[i] = e.data;
      end
    end else if (stall[i] === 1'b1) begin
      sc[i]++;
    end else begin
      sc[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) mon_one(i);
  end

  function automatic logic [2:0] non_mul_code();
    logic [2:0] c;
    c = 3'($urandom_range(0, 6));
    if (c >= 3'd4) c = c + 3'd1;
    return c;
  endfunction

  // Called just after a posedge; issues one MUL and pushes expectations.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] mask);
    exp_t e;
    #1;
    start = 1'b1; ctrl = 3'b100; kill = 1'b0; d1 = a; d2 = b;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        e.data = ref_mul(a, b);
        e.cyc  = cyc + 1 + nit[i];
        qpush(i, e);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("stall_issue", i, W'(stall[i]), W'(1));
    @(posedge clk);
    #1;
    start = 1'($urandom); ctrl = non_mul_code(); d1 = $urandom; d2 = $urandom;
  endtask

  // Waits for all queued results, toggling ignored inputs meanwhile.
  task automatic wait_idle(input int bound);
    int c;
    c = 0;
    do begin
      @(posedge clk);
      c++;
      if (pending() != 0 && c < bound) begin
        #1;
        start = 1'($urandom); ctrl = non_mul_code(); d1 = $urandom; d2 = $urandom;
      end
    end while (pending() != 0 && c < bound);
    chk("drain_timeout", 0, W'(pending()), '0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b, 3'b111);
    wait_idle(60);
  endtask

  task automatic chk_quiet(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_stall"}, i, W'(stall[i]), '0);
      chk({nm, "_busy"}, i, W'(busy[i]), '0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; ctrl = 3'b100; kill = 1'b0; d1 = 7; d2 = 6;

    // Reset held with a MUL presented: everything stays quiet.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("rst_stall", i, W'(stall[i]), '0);
        chk("rst_busy", i, W'(busy[i]), '0);
        chk("rst_done", i, W'(done[i]), '0);
        chk("rst_data", i, dout[i], '0);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0; ctrl = 3'b000;

    // Directed products, including wrap and signed-looking operands.
    run_op(32'd7, 32'd6);
    run_op(32'hFFFF_FFFF, 32'd2);
    run_op(32'hFFFF_FFFD, 32'd5);
    run_op(32'h0001_0000, 32'h0001_0000);
    run_op(32'h1234_5678, 32'h0000_0009);
    run_op(32'h0, 32'hDEAD_BEEF);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Non-MUL codes with start asserted never stall.
    foreach (nit[k]) begin
      if (k < 2) begin
        @(posedge clk);
        #1;
        start = 1'b1; ctrl = (k == 0) ? 3'b000 : 3'b101;
        repeat (3) begin
          @(negedge clk);
          chk_quiet("nonmul");
        end
      end
    end

    // Flush in IDLE suppresses the issue.
    @(posedge clk);
    #1;
    start = 1'b1; ctrl = 3'b100; kill = 1'b1;
    @(negedge clk);
    chk_quiet("kill_idle_now");
    @(posedge clk);
    #1;
    kill = 1'b0; start = 1'b0;
    @(negedge clk);
    chk_quiet("kill_idle_next");

    // Flush in RUN cycle 10: slow instances abort, the 8-step one completes.
    @(posedge clk);
    issue(32'h0BAD_F00D, 32'h0000_1234, 3'b100);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    kill = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    kill = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("kill_run_busy", i, W'(busy[i]), '0);
      chk("kill_run_stall", i, W'(stall[i]), '0);
      chk("kill_run_data", i, dout[i], last_data[i]);
    end
    wait_idle(5);

    // Reset mid-multiply clears the result and produces no done.
    issue(32'h0000_1111, 32'h0000_2222, 3'b111);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) last_data[i] = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_stall", i, W'(stall[i]), '0);
      chk("midrst_busy", i, W'(busy[i]), '0);
      chk("midrst_data", i, dout[i], '0);
    end
    @(posedge clk);

    // Randomized back-to-back products.
    repeat (25) run_op($urandom, $urandom);
    repeat (5) run_op($urandom, 32'($urandom_range(0, 15)));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
